// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - I/D cache arbiter for the shared physical-memory port
// Optional build macro PMEM_ARB_STATS_EN adds saturating grant/conflict counters.
module pmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef PMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_i_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, TURN} state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] d_streak;
  logic       i_pend;
  logic       d_pend;
  logic       grant_i;
  logic       grant_d;

  assign i_pend = icache_read;
  assign d_pend = dcache_read | dcache_write;

  // D wins unless it has already taken MAX_STREAK grants in a row while I waited.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_pend && (!i_pend || (d_streak < MAX_STREAK)))
        grant_d = 1'b1;
      else if (i_pend)
        grant_i = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_streak <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= SERVE_D;
            d_streak <= i_pend ? (d_streak + 4'd1) : 4'd0;
          end else if (grant_i) begin
            state    <= SERVE_I;
            d_streak <= 4'd0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp)
            state <= TURN;
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The granted requester sees memory directly; everything else is held at zero.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    icache_rdata = '0;
    icache_resp  = 1'b0;
    dcache_rdata = '0;
    dcache_resp  = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = icache_address;
        icache_rdata = pmem_rdata;
        icache_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = dcache_read & ~dcache_write;
        pmem_write   = dcache_write;
        pmem_address = dcache_address;
        pmem_wdata   = dcache_wdata;
        dcache_rdata = pmem_rdata;
        dcache_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

`ifdef PMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_i_grants  <= 16'd0;
      stat_d_grants  <= 16'd0;
      stat_conflicts <= 16'd0;
    end else begin
      if (grant_i && (stat_i_grants != 16'hFFFF))
        stat_i_grants <= stat_i_grants + 16'd1;
      if (grant_d && (stat_d_grants != 16'hFFFF))
        stat_d_grants <= stat_d_grants + 16'd1;
      if ((state == IDLE) && i_pend && d_pend && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter
module tb_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         icache_read;
  logic [15:0]  icache_address;
  logic [127:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic [127:0] dcache_rdata;
  logic         dcache_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef PMEM_ARB_STATS_EN
  logic [15:0]  stat_i_grants;
  logic [15:0]  stat_d_grants;
  logic [15:0]  stat_conflicts;
`endif

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .MAX_D_STREAK(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
`ifdef PMEM_ARB_STATS_EN
    ,
    .stat_i_grants  (stat_i_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  int          n_checks;
  int          n_errors;
  logic [15:0] n_i;
  logic [15:0] n_d;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wdata, input logic [127:0] rdata);
    txn_t t;
    t.is_d  = is_d;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Memory model: waits for a grant, compares it with the scoreboard head, answers after lat cycles.
  task automatic serve_txn(input int lat, input logic drop_i, input logic drop_d, output int waited);
    txn_t e;
    int   w;
    bit   found;
    found = 1'b0;
    w     = 0;
    while (!found && w < 20) begin
      @(negedge clk);
      #1;
      w++;
      if (pmem_read || pmem_write) found = 1'b1;
    end
    waited = w;
    if (!found) begin
      check("grant_timeout", 128'd0, 128'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 128'd0, 128'd1);
      return;
    end
    e = exp_q.pop_front();
    check("pmem_address", pmem_address, e.addr);
    check("pmem_write", pmem_write, e.wr);
    check("pmem_read", pmem_read, !e.wr);
    check("pmem_wdata", pmem_wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      #1;
      check("early_resp", {icache_resp, dcache_resp}, 128'd0);
    end
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = e.rdata;
    #1;
    check("icache_resp", icache_resp, !e.is_d);
    check("dcache_resp", dcache_resp, e.is_d);
    check("icache_rdata", icache_rdata, e.is_d ? 128'd0 : e.rdata);
    check("dcache_rdata", dcache_rdata, e.is_d ? e.rdata : 128'd0);
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (drop_i) icache_read = 1'b0;
    if (drop_d) begin
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
    end
    #1;
    check("turn_strobes", {pmem_read, pmem_write}, 128'd0);
    check("turn_resp", {icache_resp, dcache_resp}, 128'd0);
    if (e.is_d) n_d++;
    else n_i++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           w;
    int           seq[10];
    logic [127:0] d_line;

    n_checks = 0;
    n_errors = 0;
    n_i = 16'd0;
    n_d = 16'd0;
    rst_n          = 1'b0;
    icache_read    = 1'b1;
    icache_address = 16'h0040;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = 16'h0000;
    dcache_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // Reset held with a pending I request
    repeat (3) @(negedge clk);
    #1;
    check("rst_strobes", {pmem_read, pmem_write}, 128'd0);
    check("rst_address", pmem_address, 128'd0);
    check("rst_wdata", pmem_wdata, 128'd0);
    check("rst_resp", {icache_resp, dcache_resp}, 128'd0);
    check("rst_irdata", icache_rdata, 128'd0);
    check("rst_drdata", dcache_rdata, 128'd0);

    // I-only read straight out of reset
    push(1'b0, 1'b0, 16'h0040, 128'd0, {16{8'hA5}});
    @(negedge clk);
    rst_n = 1'b1;
    serve_txn(3, 1'b1, 1'b0, w);
    check("first_grant_latency", 128'(w), 128'd1);

    // Simultaneous I read and D write: D first
    icache_read    = 1'b1;
    icache_address = 16'h0100;
    dcache_write   = 1'b1;
    dcache_address = 16'h1230;
    dcache_wdata   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    push(1'b1, 1'b1, 16'h1230, dcache_wdata, rand_line());
    push(1'b0, 1'b0, 16'h0100, 128'd0, rand_line());
    serve_txn(2, 1'b0, 1'b1, w);
    serve_txn(1, 1'b1, 1'b0, w);

    // Both held: streak limit yields D,D,D,D,I then restarts from zero
    seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    d_line         = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    icache_read    = 1'b1;
    icache_address = 16'h0200;
    dcache_read    = 1'b1;
    dcache_address = 16'h2040;
    dcache_wdata   = d_line;
    for (int k = 0; k < 10; k++)
      push(seq[k] != 0, 1'b0, (seq[k] != 0) ? 16'h2040 : 16'h0200,
           (seq[k] != 0) ? d_line : 128'd0, rand_line());
    for (int k = 0; k < 10; k++)
      serve_txn(1 + (k % 3), k == 9, k == 9, w);

    // Read and write together: write wins
    dcache_read    = 1'b1;
    dcache_write   = 1'b1;
    dcache_address = 16'h3000;
    dcache_wdata   = rand_line();
    push(1'b1, 1'b1, 16'h3000, dcache_wdata, rand_line());
    serve_txn(1, 1'b0, 1'b1, w);

`ifdef PMEM_ARB_STATS_EN
    check("stat_i_grants", stat_i_grants, n_i);
    check("stat_d_grants", stat_d_grants, n_d);
    check("stat_conflicts", stat_conflicts, 128'd11);
`endif

    // Async reset mid SERVE_D, then a stale response
    @(negedge clk);
    dcache_read    = 1'b1;
    dcache_address = 16'h4000;
    @(negedge clk);
    #1;
    check("pre_reset_read", pmem_read, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_strobes", {pmem_read, pmem_write}, 128'd0);
    check("async_rst_address", pmem_address, 128'd0);
    dcache_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    #1;
    check("stale_resp", {icache_resp, dcache_resp}, 128'd0);
    check("stale_rdata", dcache_rdata, 128'd0);
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    check("idle_after_stale", {pmem_read, pmem_write}, 128'd0);

    // Arbiter still serves normally afterwards
    icache_read    = 1'b1;
    icache_address = 16'h0080;
    push(1'b0, 1'b0, 16'h0080, 128'd0, rand_line());
    serve_txn(2, 1'b1, 1'b0, w);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
